// File: rtl/mips32_pipe_ctrl_if.sv
// mips32_pipe_ctrl_if: load bus, imem write port, stage instruction taps and pipeline controls.
interface mips32_pipe_ctrl_if #(parameter int AW = 10, parameter int CNTW = 16);
   logic            i_mode_run;
   logic            i_ld_valid;
   logic            o_ld_ready;
   logic [AW-1:0]   i_ld_addr;
   logic [31:0]     i_ld_data;
   logic            o_imem_we;
   logic [AW-1:0]   o_imem_waddr;
   logic [31:0]     o_imem_wdata;
   logic [31:0]     i_id_ir;
   logic [31:0]     i_ex_ir;
   logic [31:0]     i_mem_ir;
   logic [31:0]     i_wb_ir;
   logic            i_br_taken;
   logic            o_pc_rst;
   logic            o_pc_en;
   logic            o_ifid_en;
   logic            o_ifid_flush;
   logic            o_idex_bubble;
   logic [2:0]      o_state;
   logic [CNTW-1:0] o_stall_cnt;
   logic [CNTW-1:0] o_retire_cnt;
   modport master (
      output i_mode_run, i_ld_valid, i_ld_addr, i_ld_data, i_id_ir, i_ex_ir, i_mem_ir, i_wb_ir, i_br_taken,
      input  o_ld_ready, o_imem_we, o_imem_waddr, o_imem_wdata, o_pc_rst, o_pc_en, o_ifid_en,
             o_ifid_flush, o_idex_bubble, o_state, o_stall_cnt, o_retire_cnt
   );
   modport slave (
      input  i_mode_run, i_ld_valid, i_ld_addr, i_ld_data, i_id_ir, i_ex_ir, i_mem_ir, i_wb_ir, i_br_taken,
      output o_ld_ready, o_imem_we, o_imem_waddr, o_imem_wdata, o_pc_rst, o_pc_en, o_ifid_en,
             o_ifid_flush, o_idex_bubble, o_state, o_stall_cnt, o_retire_cnt
   );
endinterface

// File: rtl/mips32_pipe_ctrl.sv
// mips32_pipe_ctrl: run-mode FSM, RAW-hazard stall, branch flush and imem loader for the 5-stage mips32 core.
// No forwarding: ID waits until every in-flight writer, including the register-file write cycle, has passed.
module mips32_pipe_ctrl #(parameter int AW = 10, parameter int CNTW = 16) (
   input  logic             clk,
   input  logic             rst,
   mips32_pipe_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DRAIN = 3'd3, HALTED = 3'd4} state_t;
   localparam logic [31:0] NOP      = 32'hF800_0000;
   localparam logic [5:0]  OP_HLT   = 6'b111111;
   localparam logic [5:0]  OP_LD    = 6'b110000;
   localparam logic [5:0]  OP_ST    = 6'b110001;
   localparam logic [5:0]  OP_BEQZ  = 6'b110010;
   localparam logic [5:0]  OP_BNEQZ = 6'b110011;
   state_t          r_state, w_next;
   logic            r_pc_rst, w_pc_rst;
   logic            r_imem_we;
   logic [AW-1:0]   r_waddr;
   logic [31:0]     r_wdata;
   logic            r_wb_vld;
   logic [4:0]      r_wb_rd;
   logic [CNTW-1:0] r_stall_cnt, r_retire_cnt;
   logic [5:0]      w_op;
   logic [4:0]      w_src1, w_src2;
   logic            w_need1, w_need2, w_hz, w_run, w_br, w_xfer, w_empty;
   logic            w_stall_inc, w_retire_inc, w_unused;
   // hi = IR[31:21]: opcode and rd, enough to tell whether the instruction writes reg r
   function automatic logic hit(input logic [10:0] hi, input logic [4:0] r);
      return (!hi[10] || hi[10:5] == OP_LD) && hi[4:0] == r;
   endfunction
   function automatic logic busy(input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
                                 input logic wv, input logic [4:0] wr, input logic [4:0] r);
      return hit(ex[31:21], r) || hit(mem[31:21], r) || hit(wb[31:21], r) || (wv && wr == r);
   endfunction
   assign w_op    = bus.i_id_ir[31:26];
   assign w_src1  = bus.i_id_ir[20:16];
   assign w_src2  = w_op == OP_ST ? bus.i_id_ir[25:21] : bus.i_id_ir[15:11];
   assign w_need1 = !w_op[5] || w_op == OP_LD || w_op == OP_ST || w_op == OP_BEQZ || w_op == OP_BNEQZ;
   assign w_need2 = w_op[5:4] == 2'b00 || w_op == OP_ST;
   assign w_hz    = (w_need1 && busy(bus.i_ex_ir, bus.i_mem_ir, bus.i_wb_ir, r_wb_vld, r_wb_rd, w_src1)) ||
                    (w_need2 && busy(bus.i_ex_ir, bus.i_mem_ir, bus.i_wb_ir, r_wb_vld, r_wb_rd, w_src2));
   // the pc_rst cycle sees stale stage registers, so it neither fetches, stalls nor decodes HLT
   assign w_run   = r_state == RUN && !r_pc_rst;
   assign w_br    = w_run && bus.i_br_taken;
   assign w_xfer  = bus.i_ld_valid && bus.o_ld_ready;
   assign w_empty = bus.i_ex_ir == NOP && bus.i_mem_ir == NOP && bus.i_wb_ir == NOP;
   assign w_stall_inc  = w_run && w_hz && !bus.i_br_taken && !(&r_stall_cnt);
   assign w_retire_inc = (w_run || r_state == DRAIN) && bus.i_wb_ir != NOP && !(&r_retire_cnt);
   assign w_unused     = ^bus.i_id_ir[10:0];
   always_comb begin
      w_next   = r_state;
      w_pc_rst = 1'b0;
      case (r_state)
         IDLE, LOAD: begin
            w_next   = bus.i_mode_run ? RUN : w_xfer ? LOAD : r_state;
            w_pc_rst = bus.i_mode_run;
         end
         RUN: begin
            w_next   = !bus.i_mode_run ? IDLE : (w_run && w_op == OP_HLT && !bus.i_br_taken) ? DRAIN : RUN;
            w_pc_rst = !bus.i_mode_run;
         end
         DRAIN: begin
            w_next   = !bus.i_mode_run ? IDLE : w_empty ? HALTED : DRAIN;
            w_pc_rst = !bus.i_mode_run;
         end
         HALTED: w_next = bus.i_mode_run ? HALTED : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pc_rst     <= 1'b0;
         r_imem_we    <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_wb_vld     <= 1'b0;
         r_wb_rd      <= '0;
         r_stall_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_state      <= w_next;
         r_pc_rst     <= w_pc_rst;
         r_imem_we    <= w_xfer;
         r_waddr      <= w_xfer ? bus.i_ld_addr : r_waddr;
         r_wdata      <= w_xfer ? bus.i_ld_data : r_wdata;
         r_wb_vld     <= !r_pc_rst && hit(bus.i_wb_ir[31:21], bus.i_wb_ir[25:21]);
         r_wb_rd      <= bus.i_wb_ir[25:21];
         r_stall_cnt  <= r_pc_rst ? '0 : r_stall_cnt + CNTW'(w_stall_inc);
         r_retire_cnt <= r_pc_rst ? '0 : r_retire_cnt + CNTW'(w_retire_inc);
      end
   end
   assign bus.o_ld_ready    = r_state == IDLE || r_state == LOAD;
   assign bus.o_imem_we     = r_imem_we;
   assign bus.o_imem_waddr  = r_waddr;
   assign bus.o_imem_wdata  = r_wdata;
   assign bus.o_pc_rst      = r_pc_rst;
   assign bus.o_pc_en       = w_run && (bus.i_br_taken || !w_hz);
   assign bus.o_ifid_en     = w_run && (bus.i_br_taken || !w_hz);
   assign bus.o_ifid_flush  = w_br;
   assign bus.o_idex_bubble = r_state == DRAIN || (w_run && (bus.i_br_taken || w_hz));
   assign bus.o_state       = r_state;
   assign bus.o_stall_cnt   = r_stall_cnt;
   assign bus.o_retire_cnt  = r_retire_cnt;
endmodule

// File: tb/tb_mips32_pipe_ctrl.sv
// tb_mips32_pipe_ctrl: drives a small 5-stage pipeline model around the controller;
// expectations go into queues and a negedge monitor pops and compares them.
module tb_mips32_pipe_ctrl;
   localparam logic [31:0] NOP = 32'hF800_0000;
   localparam logic [31:0] HLT = 32'hFC00_0000;
   localparam logic [9:0]  TGT = 10'd8;
   typedef struct {string name; int sel; int exp;} chk_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   mips32_pipe_ctrl_if #(.AW(10), .CNTW(4)) b();
   mips32_pipe_ctrl #(.AW(10), .CNTW(4)) dut (.clk(clk), .rst(rst), .bus(b));
   logic [31:0] imem [1024] = '{default: NOP};
   logic [31:0] id_r = NOP, ex_r = NOP, mem_r = NOP, wb_r = NOP;
   logic [9:0]  pc = '0;
   int cyc = 0, n_cmp = 0, n_err = 0, n_pcrst = 0, n_flush = 0, t_add = 0, t_sub = 0;
   logic s_pc_rst = 0, s_pc_en = 0, s_ifid_en = 0, s_flush = 0, s_bub = 0, s_br = 0;
   chk_t q_chk[$];
   logic [41:0] q_wr[$];
   function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs1, input int rs2);
      return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
   endfunction
   localparam logic [31:0] ADD_A = {6'b000000, 5'd3, 5'd1, 5'd2, 11'd0};
   localparam logic [31:0] SUB_B = {6'b000001, 5'd4, 5'd3, 5'd1, 11'd0};
   assign b.i_id_ir    = id_r;
   assign b.i_ex_ir    = ex_r;
   assign b.i_mem_ir   = mem_r;
   assign b.i_wb_ir    = wb_r;
   assign b.i_br_taken = ex_r[31:26] == 6'b110010;
   // pipeline datapath model, steered by controls sampled at the previous negedge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || s_pc_rst) begin
         pc <= '0; id_r <= NOP; ex_r <= NOP; mem_r <= NOP; wb_r <= NOP;
      end else begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         ex_r  <= s_bub ? NOP : id_r;
         id_r  <= s_flush ? NOP : s_ifid_en ? imem[pc] : id_r;
         if (s_pc_en) pc <= s_br ? TGT : pc + 10'd1;
      end
   end
   function automatic int val(input int sel);
      case (sel)
         0: return int'(b.o_state);
         1: return int'(b.o_stall_cnt);
         2: return int'(b.o_retire_cnt);
         3: return int'(b.o_ld_ready);
         4: return int'(b.o_pc_en);
         5: return int'(b.o_imem_we);
         6: return n_pcrst;
         7: return n_flush;
         8: return t_sub - t_add;
         9: return int'(b.o_ifid_en);
         default: return q_wr.size();
      endcase
   endfunction
   always @(negedge clk) begin
      chk_t c;
      logic [41:0] e;
      int v;
      s_pc_rst = b.o_pc_rst; s_pc_en = b.o_pc_en; s_ifid_en = b.o_ifid_en;
      s_flush = b.o_ifid_flush; s_bub = b.o_idex_bubble; s_br = b.i_br_taken;
      n_pcrst += int'(b.o_pc_rst);
      n_flush += int'(b.o_ifid_flush);
      if (b.i_ex_ir == ADD_A) t_add = cyc;
      if (b.i_ex_ir == SUB_B) t_sub = cyc;
      if (b.o_imem_we) begin
         n_cmp++;
         if (q_wr.size() == 0) begin
            n_err++;
            $display("FAIL imem_write: got unexpected write addr %0d data %h, expected none", b.o_imem_waddr, b.o_imem_wdata);
         end else begin
            e = q_wr.pop_front();
            if ({b.o_imem_waddr, b.o_imem_wdata} != e) begin
               n_err++;
               $display("FAIL imem_write: got addr %0d data %h, expected addr %0d data %h",
                        b.o_imem_waddr, b.o_imem_wdata, e[41:32], e[31:0]);
            end
         end
         imem[b.o_imem_waddr] = b.o_imem_wdata;
      end
      while (q_chk.size() != 0) begin
         c = q_chk.pop_front();
         v = val(c.sel);
         n_cmp++;
         if (v != c.exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", c.name, v, c.exp);
         end
         if (c.sel == 6) n_pcrst = 0;
         if (c.sel == 7) n_flush = 0;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int sel, input int exp);
      q_chk.push_back('{name, sel, exp});
   endtask
   task automatic ld(input int a, input logic [31:0] d);
      b.i_ld_valid = 1'b1;
      b.i_ld_addr  = 10'(a);
      b.i_ld_data  = d;
      q_wr.push_back({10'(a), d});
      tick();
      b.i_ld_valid = 1'b0;
   endtask
   task automatic run(input int n);
      b.i_mode_run = 1'b1;
      repeat (n) tick();
   endtask
   task automatic stop();
      b.i_mode_run = 1'b0;
      repeat (2) tick();
   endtask
   initial begin
      rst = 1'b1;
      b.i_mode_run = 1'b0; b.i_ld_valid = 1'b0; b.i_ld_addr = '0; b.i_ld_data = '0;
      tick(); tick();
      chk("rst_state", 0, 0); chk("rst_ld_ready", 3, 1); chk("rst_imem_we", 5, 0);
      chk("rst_pc_en", 4, 0); chk("rst_stall", 1, 0); chk("rst_retire", 2, 0);
      tick();
      rst = 1'b0;
      tick();
      ld(0, ADD_A); ld(1, SUB_B); ld(2, NOP);
      chk("load_state", 0, 1);
      run(16);
      chk("raw_pc_rst_pulses", 6, 1); chk("raw_state", 0, 2); chk("raw_stall", 1, 4);
      chk("raw_sub_ex_delay", 8, 5); chk("raw_retire", 2, 2); chk("raw_ld_ready", 3, 0);
      stop();
      chk("abort_pc_rst", 6, 1); chk("abort_state", 0, 0); chk("abort_stall_clr", 1, 0);
      ld(0, enc(6'b110010, 0, 0, 0)); ld(1, enc(6'b000000, 7, 8, 9)); ld(2, enc(6'b000000, 10, 11, 12));
      ld(8, enc(6'b000000, 13, 14, 15));
      run(16);
      chk("br_pc_rst", 6, 1); chk("br_flush_cycles", 7, 1); chk("br_stall", 1, 0); chk("br_retire", 2, 2);
      stop();
      chk("br_abort_pc_rst", 6, 1);
      ld(0, enc(6'b110000, 5, 1, 0)); ld(1, enc(6'b000000, 9, 6, 6)); ld(2, enc(6'b110001, 5, 2, 0));
      run(16);
      chk("lu_pc_rst", 6, 1); chk("lu_stall", 1, 3);
      stop();
      chk("lu_abort_pc_rst", 6, 1);
      ld(0, enc(6'b000000, 1, 2, 3)); ld(1, enc(6'b000000, 4, 5, 6)); ld(2, HLT);
      run(7);
      chk("hlt_drain_state", 0, 3); chk("hlt_drain_pc_en", 4, 0);
      repeat (7) tick();
      chk("hlt_pc_rst", 6, 1); chk("hlt_halted", 0, 4); chk("hlt_retire", 2, 3);
      chk("hlt_pc_en", 4, 0); chk("hlt_ifid_en", 9, 0);
      stop();
      chk("halt_idle_state", 0, 0); chk("halt_idle_no_pc_rst", 6, 0); chk("halt_idle_retire_kept", 2, 3);
      for (int i = 0; i < 20; i++) ld(i, enc(6'b000000, 1, 2, 3));
      run(30);
      chk("sat_pc_rst", 6, 1); chk("sat_retire", 2, 15); chk("sat_stall", 1, 0);
      stop();
      chk("sat_abort_pc_rst", 6, 1);
      run(6);
      #2 rst = 1'b1;
      b.i_mode_run = 1'b0;
      chk("midrun_rst_state", 0, 0); chk("midrun_rst_pc_en", 4, 0);
      chk("midrun_rst_ld_ready", 3, 1); chk("midrun_rst_retire", 2, 0);
      tick();
      rst = 1'b0;
      tick();
      ld(1023, 32'h1234_5678); ld(0, 32'h9ABC_DEF0);
      tick();
      b.i_ld_valid = 1'b1; b.i_ld_addr = 10'd5; b.i_ld_data = 32'hDEAD_BEEF;
      tick();
      b.i_ld_valid = 1'b0;
      #1 rst = 1'b1;
      chk("drop_imem_we", 5, 0); chk("drop_state", 0, 0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("writes_outstanding", 10, 0);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
